// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines and debounces ps2_clk; emits a one-cycle
// pulse when the filtered clock falls, plus the synchronised data level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_fall_edge,
    output logic o_data
);

    localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_fall;
    logic          w_done;

    assign w_done = (r_cnt == CW'(FILTER_LEN - 1));

    // Idle bus level is high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else if (r_clk_sync[1] == r_filt) begin
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else if (w_done) begin
            r_filt <= r_clk_sync[1];
            r_cnt  <= '0;
            r_fall <= r_filt;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_fall <= 1'b0;
        end
    end

    assign o_fall_edge = r_fall;
    assign o_data      = r_dat_sync[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix stripping.
// Optional partial-frame timeout is enabled by defining PS2_TIMEOUT_EN.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       newKey,
    output logic [7:0] keyCode,
    output logic       extended,
    output logic       frame_err
);

    logic w_fall;
    logic w_data;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk         (clk),
        .reset       (reset),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_fall_edge (w_fall),
        .o_data      (w_data)
    );

    frame_state_t r_state, w_state_n;
    logic [2:0]   r_cnt, w_cnt_n;
    logic [7:0]   r_shift, w_shift_n;
    logic         r_par, w_par_n;
    logic         r_ext, w_ext_n;
    logic         r_brk, w_brk_n;
    logic         r_newkey, w_newkey_n;
    logic         r_err, w_err_n;
    logic [7:0]   r_code, w_code_n;
    logic         r_extout, w_extout_n;
    logic         w_timeout;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_to;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_to <= '0;
        else if (w_fall || r_state == IDLE)
            r_to <= '0;
        else
            r_to <= r_to + 1'b1;
    end

    assign w_timeout = (r_state != IDLE) && !w_fall && (r_to == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_newkey <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= '0;
            r_extout <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_shift  <= w_shift_n;
            r_par    <= w_par_n;
            r_ext    <= w_ext_n;
            r_brk    <= w_brk_n;
            r_newkey <= w_newkey_n;
            r_err    <= w_err_n;
            r_code   <= w_code_n;
            r_extout <= w_extout_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_shift_n  = r_shift;
        w_par_n    = r_par;
        w_ext_n    = r_ext;
        w_brk_n    = r_brk;
        w_newkey_n = 1'b0;
        w_err_n    = 1'b0;
        w_code_n   = r_code;
        w_extout_n = r_extout;

        if (w_timeout) begin
            w_state_n = IDLE;
            w_err_n   = 1'b1;
            w_ext_n   = 1'b0;
            w_brk_n   = 1'b0;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_data) begin
                        w_state_n = DATA;
                        w_cnt_n   = '0;
                    end
                end
                DATA: begin
                    w_shift_n = {w_data, r_shift[7:1]};
                    w_cnt_n   = r_cnt + 1'b1;
                    if (r_cnt == 3'd7)
                        w_state_n = PARITY;
                end
                PARITY: begin
                    w_par_n   = w_data;
                    w_state_n = STOP;
                end
                STOP: begin
                    w_state_n = IDLE;
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    if (w_data && (^{r_shift, r_par})) begin
                        if (r_shift == PS2_PREFIX_EXT) begin
                            w_ext_n = 1'b1;
                        end else if (r_shift == PS2_PREFIX_BRK) begin
                            w_brk_n = 1'b1;
                        end else begin
                            if (!r_brk) begin
                                w_newkey_n = 1'b1;
                                w_code_n   = r_shift;
                                w_extout_n = r_ext;
                            end
                            w_ext_n = 1'b0;
                            w_brk_n = 1'b0;
                        end
                    end else begin
                        w_err_n = 1'b1;
                        w_ext_n = 1'b0;
                        w_brk_n = 1'b0;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign newKey    = r_newkey;
    assign keyCode   = r_code;
    assign extended  = r_extout;
    assign frame_err = r_err;

endmodule
